// File: rtl/limbus_sys_cpu_debug_pkg.sv
// Shared types and jdo field positions for the debug memory sequencer.
package limbus_sys_cpu_debug_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR_REQ  = 2'd3
    } seq_state_e;

    // Decoded command, after strobe priority has been applied.
    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_SET_ADDR  = 3'd1,
        CMD_ADDR_READ = 3'd2,
        CMD_READ      = 3'd3,
        CMD_WRITE     = 3'd4
    } seq_cmd_e;

    // Field positions inside the 38-bit jdo payload.
    localparam int JDO_W         = 38;
    localparam int JDO_RD_BIT    = 35;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/limbus_sys_cpu_debug_wait_timer.sv
// Saturating stall counter. 'expired' fires in the cycle whose stall would
// bring the count up to TIMEOUT, so the request is released after exactly
// TIMEOUT stalled cycles. TIMEOUT is expected to be at least 1.
module limbus_sys_cpu_debug_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [CNT_W-1:0] count_r;

    // Count stalled cycles, cleared whenever no request is outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Flag the stall that completes the allowed budget.
    always_comb begin
        expired = 1'b0;
        if (enable && (count_r >= LAST)) begin
            expired = 1'b1;
        end else begin
            expired = 1'b0;
        end
    end

endmodule

// File: rtl/limbus_sys_cpu_debug_mem_sequencer.sv
// Sysclk-side sequencer for JTAG debug accesses to the OCI RAM: decodes the
// ocimem strobes, runs single-word reads/writes with address auto-increment,
// rejects writes to the debug ROM and abandons requests stalled too long.
module limbus_sys_cpu_debug_mem_sequencer
    import limbus_sys_cpu_debug_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ROM_WORDS = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    // One extra bit so ROM_WORDS == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W + 1)'(ROM_WORDS);

    seq_state_e        state_r;
    logic [ADDR_W-1:0] addr_r;

    seq_cmd_e          cmd_s;
    logic              any_strobe_s;
    logic [ADDR_W-1:0] jdo_addr_s;
    logic [31:0]       jdo_wdata_s;
    logic              rom_hit_s;
    logic              timer_clear_s;
    logic              timer_enable_s;
    logic              expired_s;
    logic              unused_jdo_s;

    assign jdo_addr_s   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_wdata_s  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
    assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

    // Resolve simultaneous strobes: write beats address phase beats plain read.
    always_comb begin
        cmd_s = CMD_NONE;
        if (take_action_ocimem_b) begin
            cmd_s = CMD_WRITE;
        end else if (take_action_ocimem_a) begin
            if (jdo[JDO_RD_BIT]) begin
                cmd_s = CMD_ADDR_READ;
            end else begin
                cmd_s = CMD_SET_ADDR;
            end
        end else if (take_no_action_ocimem_a) begin
            cmd_s = CMD_READ;
        end else begin
            cmd_s = CMD_NONE;
        end
    end

    // Status helpers: any strobe present, write target inside debug ROM.
    always_comb begin
        any_strobe_s = 1'b0;
        rom_hit_s    = 1'b0;
        if (take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b) begin
            any_strobe_s = 1'b1;
        end else begin
            any_strobe_s = 1'b0;
        end
        if ({1'b0, addr_r} < ROM_LIMIT) begin
            rom_hit_s = 1'b1;
        end else begin
            rom_hit_s = 1'b0;
        end
    end

    // Stall timer runs only while a request is on the bus.
    always_comb begin
        timer_clear_s  = 1'b1;
        timer_enable_s = 1'b0;
        if ((state_r == ST_RD_REQ) || (state_r == ST_WR_REQ)) begin
            timer_clear_s  = 1'b0;
            timer_enable_s = mem_waitrequest;
        end else begin
            timer_clear_s  = 1'b1;
            timer_enable_s = 1'b0;
        end
    end

    limbus_sys_cpu_debug_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear_s),
        .enable  (timer_enable_s),
        .expired (expired_s)
    );

    // Transaction FSM with all bus and status outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            addr_r        <= {ADDR_W{1'b0}};
            mem_addr      <= {ADDR_W{1'b0}};
            mem_rd        <= 1'b0;
            mem_wr        <= 1'b0;
            mem_wdata     <= 32'h0000_0000;
            MonDReg       <= 32'h0000_0000;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // A strobe arriving mid-transaction is dropped but remembered.
            if ((state_r != ST_IDLE) && any_strobe_s) begin
                monitor_error <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    case (cmd_s)
                        CMD_SET_ADDR: begin
                            addr_r        <= jdo_addr_s;
                            monitor_ready <= 1'b1;
                            monitor_error <= 1'b0;
                        end
                        CMD_ADDR_READ: begin
                            addr_r        <= jdo_addr_s;
                            mem_addr      <= jdo_addr_s;
                            mem_rd        <= 1'b1;
                            busy          <= 1'b1;
                            monitor_ready <= 1'b0;
                            monitor_error <= 1'b0;
                            state_r       <= ST_RD_REQ;
                        end
                        CMD_READ: begin
                            mem_addr      <= addr_r;
                            mem_rd        <= 1'b1;
                            busy          <= 1'b1;
                            monitor_ready <= 1'b0;
                            monitor_error <= 1'b0;
                            state_r       <= ST_RD_REQ;
                        end
                        CMD_WRITE: begin
                            if (rom_hit_s) begin
                                // ROM is never written, but the debugger still
                                // sees the data echoed and the address advance.
                                MonDReg       <= jdo_wdata_s;
                                addr_r        <= addr_r + ADDR_W'(1);
                                monitor_ready <= 1'b1;
                                monitor_error <= 1'b1;
                            end else begin
                                mem_addr      <= addr_r;
                                mem_wdata     <= jdo_wdata_s;
                                mem_wr        <= 1'b1;
                                busy          <= 1'b1;
                                monitor_ready <= 1'b0;
                                monitor_error <= 1'b0;
                                state_r       <= ST_WR_REQ;
                            end
                        end
                        default: begin
                            state_r <= ST_IDLE;
                        end
                    endcase
                end
                ST_RD_REQ: begin
                    if (!mem_waitrequest) begin
                        mem_rd  <= 1'b0;
                        state_r <= ST_RD_DATA;
                    end else if (expired_s) begin
                        mem_rd        <= 1'b0;
                        busy          <= 1'b0;
                        monitor_ready <= 1'b1;
                        monitor_error <= 1'b1;
                        state_r       <= ST_IDLE;
                    end
                end
                ST_RD_DATA: begin
                    MonDReg       <= mem_rdata;
                    addr_r        <= addr_r + ADDR_W'(1);
                    busy          <= 1'b0;
                    monitor_ready <= 1'b1;
                    state_r       <= ST_IDLE;
                end
                ST_WR_REQ: begin
                    if (!mem_waitrequest) begin
                        mem_wr        <= 1'b0;
                        MonDReg       <= mem_wdata;
                        addr_r        <= addr_r + ADDR_W'(1);
                        busy          <= 1'b0;
                        monitor_ready <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else if (expired_s) begin
                        mem_wr        <= 1'b0;
                        busy          <= 1'b0;
                        monitor_ready <= 1'b1;
                        monitor_error <= 1'b1;
                        state_r       <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_limbus_sys_cpu_debug_mem_sequencer.sv
// Directed bench for the debug memory sequencer: a transaction-level model
// checked every cycle, plus literal expectations taken from the test plan.
module tb_limbus_sys_cpu_debug_mem_sequencer;

    localparam int ROM_WORDS = 64;
    localparam int TIMEOUT   = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = 38'd0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h5A5A_5A5A;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;
    int rd_rises = 0;
    logic rd_prev = 1'b0;

    logic [31:0] mem [256];

    limbus_sys_cpu_debug_mem_sequencer #(
        .ADDR_W    (8),
        .ROM_WORDS (ROM_WORDS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .mem_addr                (mem_addr),
        .mem_rd                  (mem_rd),
        .mem_wr                  (mem_wr),
        .mem_wdata               (mem_wdata),
        .mem_rdata               (mem_rdata),
        .mem_waitrequest         (mem_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory slave: data appears for exactly the cycle after a read is accepted.
    always @(posedge clk) begin
        logic       rd_acc;
        logic [7:0] rd_addr;
        rd_acc  = reset_n && mem_rd && !mem_waitrequest;
        rd_addr = mem_addr;
        if (reset_n && mem_wr && !mem_waitrequest) mem[mem_addr] = mem_wdata;
        #1;
        mem_rdata = rd_acc ? mem[rd_addr] : 32'h5A5A_5A5A;
    end

    // ---------------- transaction-level reference model ----------------
    logic [7:0]  e_addr, e_maddr;
    logic [31:0] e_mon, e_wdata;
    logic        e_ready, e_error, e_busy, e_rd, e_wr;
    int          t_kind;      // 0 none, 1 read, 2 write
    bit          t_data_due;
    int          t_stalls;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_addr = 8'd0; e_maddr = 8'd0; e_mon = 32'd0; e_wdata = 32'd0;
            e_ready = 1'b0; e_error = 1'b0; e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
            t_kind = 0; t_data_due = 1'b0; t_stalls = 0;
        end else if (t_kind == 0) begin
            if (take_action_ocimem_b) begin
                e_ready = 1'b0; e_error = 1'b0;
                if (int'(e_addr) < ROM_WORDS) begin
                    e_mon = jdo[34:3]; e_addr = e_addr + 8'd1;
                    e_ready = 1'b1; e_error = 1'b1;
                end else begin
                    e_maddr = e_addr; e_wdata = jdo[34:3]; e_wr = 1'b1; e_busy = 1'b1;
                    t_kind = 2; t_stalls = 0;
                end
            end else if (take_action_ocimem_a) begin
                e_ready = 1'b0; e_error = 1'b0; e_addr = jdo[24:17];
                if (jdo[35]) begin
                    e_maddr = e_addr; e_rd = 1'b1; e_busy = 1'b1; t_kind = 1; t_stalls = 0;
                end else begin
                    e_ready = 1'b1;
                end
            end else if (take_no_action_ocimem_a) begin
                e_ready = 1'b0; e_error = 1'b0;
                e_maddr = e_addr; e_rd = 1'b1; e_busy = 1'b1; t_kind = 1; t_stalls = 0;
            end
        end else begin
            if (take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b)
                e_error = 1'b1;
            if (t_data_due) begin
                e_mon = mem[e_maddr]; e_addr = e_addr + 8'd1;
                e_ready = 1'b1; e_busy = 1'b0; t_kind = 0; t_data_due = 1'b0;
            end else if (!mem_waitrequest) begin
                if (t_kind == 1) begin
                    e_rd = 1'b0; t_data_due = 1'b1;
                end else begin
                    e_wr = 1'b0; e_mon = e_wdata; e_addr = e_addr + 8'd1;
                    e_ready = 1'b1; e_busy = 1'b0; t_kind = 0;
                end
            end else begin
                t_stalls++;
                if (t_stalls == TIMEOUT) begin
                    e_rd = 1'b0; e_wr = 1'b0; e_ready = 1'b1; e_error = 1'b1;
                    e_busy = 1'b0; t_kind = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, on the inactive edge.
    always @(negedge clk) begin
        chk("mem_rd", {31'd0, mem_rd}, {31'd0, e_rd});
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("monitor_ready", {31'd0, monitor_ready}, {31'd0, e_ready});
        chk("monitor_error", {31'd0, monitor_error}, {31'd0, e_error});
        chk("MonDReg", MonDReg, e_mon);
        if (e_rd || e_wr) chk("mem_addr", {24'd0, mem_addr}, {24'd0, e_maddr});
        if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
        if (mem_rd) rd_cycles++;
        if (mem_wr) wr_cycles++;
        if (mem_rd && !rd_prev) rd_rises++;
        rd_prev = mem_rd;
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe_a(input logic [7:0] a, input logic rd);
        jdo = 38'd0; jdo[24:17] = a; jdo[35] = rd;
        take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] d);
        jdo = 38'd0; jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic strobe_n();
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (monitor_ready && !busy) break;
        end
        if (i >= budget) chk("wait_done_timeout", 32'd1, 32'd0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'hC0, 8'(i), 16'h0000};
        mem[8'h40] = 32'hDEAD_BEEF; mem[8'h41] = 32'h0BAD_F00D;
        mem[8'h00] = 32'h1111_0000; mem[8'h11] = 32'h2222_1111;
        mem[8'h12] = 32'h3333_2222; mem[8'h80] = 32'h4444_3333;
        mem[8'h81] = 32'h5555_4444; mem[8'h50] = 32'h6666_5555;

        tick(3);
        chk("reset_MonDReg", MonDReg, 32'h0);
        chk("reset_flags", {28'd0, mem_rd, mem_wr, monitor_ready, busy}, 32'h0);
        chk("reset_mem_addr", {24'd0, mem_addr}, 32'h0);
        @(negedge clk); reset_n = 1'b1;

        // Read at 0x40, zero wait: ready three cycles after the strobe.
        strobe_a(8'h40, 1'b1);
        chk("t1_rd_issue", {31'd0, mem_rd}, 32'd1);
        chk("t1_addr", {24'd0, mem_addr}, 32'h40);
        tick(1);
        chk("t1_rd_gone", {31'd0, mem_rd}, 32'd0);
        tick(1);
        chk("t1_data", MonDReg, 32'hDEAD_BEEF);
        chk("t1_ready", {30'd0, monitor_ready, busy}, 32'b10);
        @(negedge clk);
        strobe_n();
        chk("t1_autoinc", {24'd0, mem_addr}, 32'h41);
        wait_done(10);
        chk("t1b_data", MonDReg, 32'h0BAD_F00D);

        // Address-only phase at 0xFF, then a write with three stall cycles.
        strobe_a(8'hFF, 1'b0);
        chk("t2_addr_only_ready", {30'd0, monitor_ready, busy}, 32'b10);
        mem_waitrequest = 1'b1;
        wr_cycles = 0;
        strobe_b(32'h1234_5678);
        chk("t2_wr_addr", {24'd0, mem_addr}, 32'hFF);
        tick(3);
        mem_waitrequest = 1'b0;
        wait_done(10);
        chk("t2_wr_cycles", wr_cycles, 32'd4);
        chk("t2_no_error", {31'd0, monitor_error}, 32'd0);
        chk("t2_memory", mem[8'hFF], 32'h1234_5678);
        strobe_n();
        chk("t2_wrap", {24'd0, mem_addr}, 32'h00);
        wait_done(10);
        chk("t2_wrap_data", MonDReg, 32'h1111_0000);

        // Write into the ROM region is rejected in one cycle.
        strobe_a(8'h10, 1'b0);
        wr_cycles = 0;
        strobe_b(32'hA5A5_A5A5);
        chk("t3_rom_flags", {29'd0, monitor_error, monitor_ready, busy}, 32'b110);
        chk("t3_rom_echo", MonDReg, 32'hA5A5_A5A5);
        tick(2);
        chk("t3_no_wr", wr_cycles, 32'd0);
        strobe_n();
        chk("t3_rom_inc", {24'd0, mem_addr}, 32'h11);
        wait_done(10);
        chk("t3_data", MonDReg, 32'h2222_1111);
        // Back-to-back: strobe in the cycle busy falls.
        strobe_n();
        chk("t3_b2b_accept", {31'd0, busy}, 32'd1);
        chk("t3_b2b_addr", {24'd0, mem_addr}, 32'h12);
        wait_done(10);
        chk("t3_b2b_data", MonDReg, 32'h3333_2222);

        // Stuck waitrequest: read abandoned after TIMEOUT stalls.
        mem_waitrequest = 1'b1;
        rd_cycles = 0;
        strobe_a(8'h80, 1'b1);
        wait_done(400);
        chk("t4_rd_cycles", rd_cycles, 32'd255);
        chk("t4_flags", {30'd0, monitor_error, monitor_ready}, 32'b11);
        chk("t4_mon_kept", MonDReg, 32'h3333_2222);
        mem_waitrequest = 1'b0;
        strobe_n();
        chk("t4_addr_kept", {24'd0, mem_addr}, 32'h80);
        wait_done(10);
        chk("t4_retry_data", MonDReg, 32'h4444_3333);

        // Strobe while busy is dropped and flagged.
        mem_waitrequest = 1'b1;
        rd_rises = 0;
        strobe_n();
        strobe_n();
        tick(1);
        mem_waitrequest = 1'b0;
        wait_done(10);
        tick(3);
        chk("t5_data", MonDReg, 32'h5555_4444);
        chk("t5_flags", {30'd0, monitor_error, monitor_ready}, 32'b11);
        chk("t5_single_rd", rd_rises, 32'd1);

        // Reset in the middle of a read request.
        mem_waitrequest = 1'b1;
        strobe_a(8'h90, 1'b1);
        tick(1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_flags", {27'd0, mem_rd, mem_wr, monitor_ready, monitor_error, busy}, 32'h0);
        chk("t6_rst_mon", MonDReg, 32'h0);
        chk("t6_rst_bus", {mem_addr, mem_wdata[23:0]}, 32'h0);
        tick(2);
        @(negedge clk); reset_n = 1'b1;
        mem_waitrequest = 1'b0;
        strobe_a(8'h50, 1'b1);
        wait_done(10);
        chk("t6_fresh_read", MonDReg, 32'h6666_5555);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
